// File: rtl/trap_shaper_cfg.sv
// trap_shaper_cfg: runtime-configurable trapezoidal shaper with flush/warm-up and output saturation.
// Define TRAP_PEAK_DETECT_EN to add the peak_valid/peak_data peak detector.
module trap_shaper_cfg #(
  parameter int DATA_W = 12,
  parameter int OUT_W = 16,
  parameter int MAX_DELAY = 64,
  parameter int M_W = 10,
  parameter int ACC_W = 40,
  parameter int DEF_K = 16,
  parameter int DEF_L = 8,
  parameter int DEF_M = 0,
  parameter int DEF_SHIFT = 7
`ifdef TRAP_PEAK_DETECT_EN
  , parameter int PEAK_THR = 64
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  input  logic cfg_load,
  input  logic [$clog2(MAX_DELAY+1)-1:0] cfg_k,
  input  logic [$clog2(MAX_DELAY+1)-1:0] cfg_l,
  input  logic [M_W-1:0] cfg_m,
  input  logic [5:0] cfg_shift,
  output logic cfg_err,
  output logic busy,
  output logic signed [OUT_W-1:0] out_data,
  output logic out_valid
`ifdef TRAP_PEAK_DETECT_EN
  ,
  output logic peak_valid,
  output logic signed [OUT_W-1:0] peak_data
`endif
);
  localparam int KW = $clog2(MAX_DELAY+1);
  localparam int KW1 = KW + 1;
  localparam int AW = $clog2(MAX_DELAY);
  localparam logic signed [ACC_W-1:0] YMAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] YMIN = -YMAX - 1;
  typedef enum logic [1:0] {RUN, FLUSH, WARMUP} state_t;
  state_t state;
  logic [KW-1:0] k, l;
  logic [M_W-1:0] m;
  logic [5:0] shift;
  logic [KW:0] kl, cfg_kl, warm_cnt;
  logic [DATA_W-1:0] dl [MAX_DELAY];
  logic signed [ACC_W-1:0] x_e, xk, xl, xkl, m_e, a, b, d, p, md, r, s, y_sh;
  logic signed [OUT_W-1:0] y;
  logic [4:0] v, w;
  logic accept, cfg_ok, flush, fire;
  assign in_ready = !cfg_load && state != FLUSH;
  assign accept = in_valid && in_ready;
  assign busy = state != RUN;
  assign kl = {1'b0, k} + {1'b0, l};
  assign cfg_kl = {1'b0, cfg_k} + {1'b0, cfg_l};
  assign cfg_ok = cfg_l != '0 && cfg_l <= cfg_k && cfg_kl <= KW1'(MAX_DELAY) && cfg_shift <= 6'(ACC_W-1);
  assign flush = (cfg_load && cfg_ok) || state == FLUSH;
  // dl[j] holds x[n-1-j], so x[n-k] sits at index k-1
  assign x_e = ACC_W'(in_data);
  assign xk = ACC_W'(dl[AW'(k - 1'b1)]);
  assign xl = ACC_W'(dl[AW'(l - 1'b1)]);
  assign xkl = ACC_W'(dl[AW'(kl - 1'b1)]);
  assign m_e = ACC_W'(m);
  assign y_sh = s >>> shift;
  assign y = y_sh > YMAX ? OUT_W'(YMAX) : y_sh < YMIN ? OUT_W'(YMIN) : OUT_W'(y_sh);
  assign fire = v[4] && !w[4];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      k <= KW'(DEF_K);
      l <= KW'(DEF_L);
      m <= M_W'(DEF_M);
      shift <= 6'(DEF_SHIFT);
      warm_cnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_load && cfg_ok) begin
        k <= cfg_k;
        l <= cfg_l;
        m <= cfg_m;
        shift <= cfg_shift;
        state <= FLUSH;
      end else if (state == FLUSH) begin
        state <= WARMUP;
        warm_cnt <= '0;
      end else if (state == WARMUP && accept) begin
        warm_cnt <= warm_cnt + 1'b1;
        if (warm_cnt + 1'b1 == kl) state <= RUN;
      end
    end
  end
  // v/w tag each pipeline stage as carrying a real sample / a warm-up sample
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < MAX_DELAY; i++) dl[i] <= '0;
      {a, b, d, p, md, r, s} <= '0;
      v <= '0;
      w <= '0;
      out_valid <= 1'b0;
      if (reset) out_data <= '0;
    end else begin
      if (accept) begin
        for (int i = MAX_DELAY-1; i > 0; i--) dl[i] <= dl[i-1];
        dl[0] <= in_data;
      end
      v <= {v[3:0], accept};
      w <= {w[3:0], state == WARMUP};
      a <= x_e - xk;
      b <= xl - xkl;
      d <= a - b;
      if (v[1]) p <= p + d;
      md <= d * m_e;
      r <= p + md;
      if (v[3]) s <= s + r;
      out_valid <= fire;
      if (fire) out_data <= y;
    end
  end
`ifdef TRAP_PEAK_DETECT_EN
  localparam logic signed [OUT_W-1:0] THR = OUT_W'(PEAK_THR);
  logic armed;
  logic signed [OUT_W-1:0] pk_max;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      armed <= 1'b0;
      pk_max <= '0;
      peak_valid <= 1'b0;
      peak_data <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (fire && y > THR) begin
        armed <= 1'b1;
        pk_max <= (!armed || y > pk_max) ? y : pk_max;
      end else if (fire && armed) begin
        armed <= 1'b0;
        peak_valid <= 1'b1;
        peak_data <= pk_max;
      end
    end
  end
`endif
endmodule

// File: tb/tb_trap_shaper_cfg.sv
// tb_trap_shaper_cfg: scoreboard bench for trap_shaper_cfg against a direct-formula reference model.
module tb_trap_shaper_cfg;
  logic clk = 0, reset = 1, in_valid = 0, cfg_load = 0;
  logic [11:0] in_data = 0;
  logic [6:0] cfg_k = 0, cfg_l = 0;
  logic [9:0] cfg_m = 0;
  logic [5:0] cfg_shift = 0;
  logic in_ready, cfg_err, busy, out_valid;
  logic signed [15:0] out_data;

  trap_shaper_cfg dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_shift(cfg_shift),
    .cfg_err(cfg_err), .busy(busy), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int y; int due;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, err_cyc = -1;
  bit started = 0;
  int mk, ml, mm, msh, mst, wcnt;
  longint p, s;
  int hist[$];

  function automatic longint wrap40(longint x);
    return (x <<< 24) >>> 24;
  endfunction
  function automatic int sat(longint x);
    return x > 32767 ? 32767 : x < -32768 ? -32768 : int'(x);
  endfunction
  function automatic int tap(int j);
    return j <= hist.size() ? hist[j-1] : 0;
  endfunction

  task automatic check(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mk = 16; ml = 8; mm = 0; msh = 7; mst = 0; wcnt = 0; p = 0; s = 0;
    hist.delete();
    q.delete();
    err_cyc = -1;
  endtask

  // mst: 0 run, 1 flush, 2 warm-up
  task automatic step(bit v, int x, bit ld = 0, int ck = 0, int cl = 0, int cm = 0, int csh = 0);
    bit ok, acc, warm;
    int d;
    check("busy", busy, mst != 0);
    in_valid = v; in_data = 12'(x); cfg_load = ld;
    cfg_k = 7'(ck); cfg_l = 7'(cl); cfg_m = 10'(cm); cfg_shift = 6'(csh);
    #1;
    check("in_ready", in_ready, !ld && mst != 1);
    ok = cl >= 1 && cl <= ck && ck + cl <= 64 && csh <= 39;
    acc = v && !ld && mst != 1;
    warm = mst == 2;
    if (ld && !ok) err_cyc = cyc + 1;
    if (acc) begin
      d = x - tap(mk) - tap(ml) + tap(mk + ml);
      p = wrap40(p + d);
      s = wrap40(s + wrap40(p + longint'(mm) * d));
      hist.push_front(x);
      if (hist.size() > 64) void'(hist.pop_back());
      if (!warm) q.push_back('{sat(s >>> msh), cyc + 6});
    end
    if (ld && ok) begin
      mk = ck; ml = cl; mm = cm; msh = csh; mst = 1; p = 0; s = 0;
      hist.delete();
      q.delete();
    end else if (mst == 1) begin
      mst = 2; wcnt = 0;
    end else if (mst == 2 && acc) begin
      wcnt++;
      if (wcnt == mk + ml) mst = 0;
    end
    @(negedge clk); #2;
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; cfg_load = 0;
    model_reset();
    @(negedge clk); #2;
    reset = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (started && !reset) begin
      check("cfg_err", cfg_err, cyc == err_cyc);
      if (out_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_out: got out_valid=1 data %0d, expected no output at cycle %0d", out_data, cyc);
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e.y);
          check("latency", cyc, e.due);
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        tests++; fails++;
        $display("FAIL missing_out: got out_valid=0, expected data %0d due cycle %0d", q[0].y, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    #2;
    started = 1;
    do_reset();
    repeat (20) step(1, 0);
    step(0, 0, 1, 4, 2, 0, 0);
    repeat (8) step(1, 0);
    repeat (12) step(1, 100);
    repeat (8) step(0, 0);
    step(0, 0, 1, 4, 2, 2, 0);
    repeat (8) step(1, 0);
    step(1, 100);
    repeat (12) step(1, 0);
    step(0, 0, 1, 32, 16, 0, 0);
    repeat (50) step(1, 0);
    repeat (40) step(1, 4095);
    step(1, 4095, 1, 40, 30, 0, 0);
    repeat (10) step(1, 4095);
    repeat (10) step(1, 0);
    step(1, 500, 1, 4, 2, 0, 0);
    repeat (4) step(1, 300);
    do_reset();
    repeat (12) step(1, 1000);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 199);
      if (r < 5) begin
        int ck = $urandom_range(0, 48);
        step($urandom_range(0, 1) == 1, $urandom_range(0, 4095), 1, ck,
             $urandom_range(0, ck + 2), $urandom_range(0, 1023), $urandom_range(0, 44));
      end else if (r == 5) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 4095));
      end
    end
    repeat (10) step(0, 0);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
